// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    // Responder FSM encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    // Latched operation code
    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    // Width of the wait-state counter (covers 0..15)
    localparam int CNT_W = 4;

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous word RAM with registered read (read-first).
module dmem_ram #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] idx,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [0:(1<<ADDR_WIDTH)-1];

    // Write port and registered read of the addressed word
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
        rdata <= mem[idx];
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-side memory slave: serves one CPU read/write after WAIT_CYCLES wait
// states, stalling the CPU while the access is in flight.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        cpu_rst_n,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_dout,
    output logic [31:0] mem_din,
    output logic        mem_stall,
    output logic        mem_err,
    output logic [15:0] acc_cnt
);

    localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);

    state_t                  state_reg, state_next;
    logic [CNT_W-1:0]        cnt_reg;
    logic [ADDR_WIDTH-1:0]   idx_reg;
    logic [31:0]             wdata_reg;
    logic                    op_reg;
    logic [31:0]             din_hold_reg;
    logic                    err_reg;
    logic [15:0]             acc_reg;

    logic                    req;
    logic                    accept;
    logic                    stall_raw;
    logic                    commit;
    logic [ADDR_WIDTH-1:0]   ram_idx;
    logic [31:0]             ram_wdata;
    logic                    ram_op;
    logic                    ram_we;
    logic [31:0]             ram_rdata;
    logic                    addr_hi_unused;

    // Upper address bits alias onto the RAM and are deliberately dropped
    assign addr_hi_unused = &{1'b0, mem_addr[31:ADDR_WIDTH+2]};

    assign req    = mem_ren | mem_wen;
    assign accept = (state_reg == IDLE) && req;

    // Next-state and raw stall decode
    always_comb begin
        state_next = state_reg;
        stall_raw  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req) begin
                    stall_raw  = 1'b1;
                    state_next = (WAIT_CYCLES > 0) ? WAIT : DONE;
                end
            end
            WAIT: begin
                stall_raw = 1'b1;
                if (cnt_reg == CNT_W'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Stall must not leak out while the CPU is held in reset
    assign mem_stall = stall_raw & cpu_rst_n;

    // With zero wait states the commit edge is the acceptance edge, so the RAM
    // sees the live request; otherwise it sees the latched copy.
    assign ram_idx   = accept ? mem_addr[ADDR_WIDTH+1:2] : idx_reg;
    assign ram_wdata = accept ? mem_dout : wdata_reg;
    assign ram_op    = accept ? (mem_wen ? OP_WR : OP_RD) : op_reg;
    assign commit    = (state_next == DONE) && cpu_rst_n;
    assign ram_we    = commit && (ram_op == OP_WR);

    dmem_ram #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .idx  (ram_idx),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

    // FSM state, wait counter, latched request and status registers
    always_ff @(posedge clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            idx_reg      <= '0;
            wdata_reg    <= '0;
            op_reg       <= OP_RD;
            din_hold_reg <= '0;
            err_reg      <= 1'b0;
            acc_reg      <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                cnt_reg   <= WAIT_LD;
                idx_reg   <= mem_addr[ADDR_WIDTH+1:2];
                wdata_reg <= mem_dout;
                op_reg    <= mem_wen ? OP_WR : OP_RD;
                if (mem_addr[1:0] != 2'b00) begin
                    err_reg <= 1'b1;
                end
            end else if (state_reg == WAIT) begin
                cnt_reg <= cnt_reg - CNT_W'(1);
            end
            if (state_reg == DONE) begin
                acc_reg <= acc_reg + 16'd1;
                if (op_reg == OP_RD) begin
                    din_hold_reg <= ram_rdata;
                end
            end
        end
    end

    // Read data is live from the RAM register in DONE and held afterwards
    assign mem_din = ((state_reg == DONE) && (op_reg == OP_RD)) ? ram_rdata : din_hold_reg;
    assign mem_err = err_reg;
    assign acc_cnt = acc_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a two-wait-state instance for the main
// scenarios and a zero-wait-state instance for latency and counter wrap.
module tb_dmem_responder;

    int checks = 0;
    int errors = 0;

    // Instance with WAIT_CYCLES=2
    logic        clk = 1'b0;
    logic        cpu_rst_n;
    logic        mem_ren, mem_wen;
    logic [31:0] mem_addr, mem_dout;
    logic [31:0] mem_din;
    logic        mem_stall, mem_err;
    logic [15:0] acc_cnt;

    // Instance with WAIT_CYCLES=0
    logic        clk0 = 1'b0;
    logic        rst0_n;
    logic        ren0, wen0;
    logic [31:0] addr0, dout0;
    logic [31:0] din0;
    logic        stall0, err0;
    logic [15:0] acc0;

    always #5 clk  = ~clk;
    always #2 clk0 = ~clk0;

    dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) dut (
        .clk(clk), .cpu_rst_n(cpu_rst_n), .mem_ren(mem_ren), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_din(mem_din),
        .mem_stall(mem_stall), .mem_err(mem_err), .acc_cnt(acc_cnt)
    );

    dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut0 (
        .clk(clk0), .cpu_rst_n(rst0_n), .mem_ren(ren0), .mem_wen(wen0),
        .mem_addr(addr0), .mem_dout(dout0), .mem_din(din0),
        .mem_stall(stall0), .mem_err(err0), .acc_cnt(acc0)
    );

    // One access on the WAIT_CYCLES=2 instance; reports cycle counts and DONE data
    task automatic access(input logic ren, input logic wen, input logic [31:0] addr,
                          input logic [31:0] data, output int total, output int stalls,
                          output logic [31:0] din_done);
        @(posedge clk); #1;
        mem_ren = ren; mem_wen = wen; mem_addr = addr; mem_dout = data;
        total = 0; stalls = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            total++;
            if (mem_stall) stalls++;
            else break;
        end
        din_done = mem_din;
        @(posedge clk); #1;
        mem_ren = 1'b0; mem_wen = 1'b0;
        $display("access ren=%0b wen=%0b addr=%h data=%h cycles=%0d stalls=%0d din=%h",
                 ren, wen, addr, data, total, stalls, din_done);
    endtask

    // One access on the WAIT_CYCLES=0 instance
    task automatic access0(input logic ren, input logic wen, input logic [31:0] addr,
                           input logic [31:0] data, output int total, output int stalls,
                           output logic [31:0] din_done);
        @(posedge clk0); #1;
        ren0 = ren; wen0 = wen; addr0 = addr; dout0 = data;
        total = 0; stalls = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk0);
            total++;
            if (stall0) stalls++;
            else break;
        end
        din_done = din0;
        @(posedge clk0); #1;
        ren0 = 1'b0; wen0 = 1'b0;
        $display("access0 ren=%0b wen=%0b addr=%h data=%h cycles=%0d stalls=%0d din=%h",
                 ren, wen, addr, data, total, stalls, din_done);
    endtask

    task automatic test_reset();
        cpu_rst_n = 1'b0; mem_ren = 1'b1; mem_wen = 1'b0; mem_addr = 32'h0; mem_dout = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", mem_stall); end
        checks++; if (mem_din !== 32'h0) begin errors++; $display("FAIL reset_din got=%h exp=0", mem_din); end
        checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", mem_err); end
        checks++; if (acc_cnt !== 16'h0) begin errors++; $display("FAIL reset_acc got=%h exp=0", acc_cnt); end
        mem_ren = 1'b0;
        cpu_rst_n = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_write_read();
        int t, s; logic [31:0] d;
        access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, t, s, d);
        checks++; if (s != 3) begin errors++; $display("FAIL wr_stalls got=%0d exp=3", s); end
        checks++; if (t != 4) begin errors++; $display("FAIL wr_cycles got=%0d exp=4", t); end
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL wr_din_unchanged got=%h exp=0", d); end
        access(1'b1, 1'b0, 32'h10, 32'h0, t, s, d);
        checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got=%h exp=deadbeef", d); end
        checks++; if (t != 4) begin errors++; $display("FAIL rd_cycles got=%0d exp=4", t); end
        checks++; if (acc_cnt !== 16'd2) begin errors++; $display("FAIL wr_rd_acc got=%0d exp=2", acc_cnt); end
    endtask

    task automatic test_misaligned();
        int t, s; logic [31:0] d;
        access(1'b0, 1'b1, 32'h13, 32'h12345678, t, s, d);
        checks++; if (mem_err !== 1'b1) begin errors++; $display("FAIL mis_err_set got=%b exp=1", mem_err); end
        access(1'b1, 1'b0, 32'h10, 32'h0, t, s, d);
        checks++; if (d !== 32'h12345678) begin errors++; $display("FAIL mis_rd got=%h exp=12345678", d); end
        checks++; if (mem_err !== 1'b1) begin errors++; $display("FAIL mis_err_sticky got=%b exp=1", mem_err); end
    endtask

    task automatic test_both_high();
        int t, s; logic [31:0] d;
        access(1'b1, 1'b1, 32'h8, 32'h1, t, s, d);
        checks++; if (d !== 32'h12345678) begin errors++; $display("FAIL both_din_held got=%h exp=12345678", d); end
        access(1'b1, 1'b0, 32'h8, 32'h0, t, s, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL both_rd got=%h exp=1", d); end
    endtask

    task automatic test_alias();
        int t, s; logic [31:0] d;
        access(1'b0, 1'b1, 32'h1000, 32'hCAFEF00D, t, s, d);
        access(1'b1, 1'b0, 32'h0, 32'h0, t, s, d);
        checks++; if (d !== 32'hCAFEF00D) begin errors++; $display("FAIL alias_rd got=%h exp=cafef00d", d); end
        checks++; if (acc_cnt !== 16'd8) begin errors++; $display("FAIL alias_acc got=%0d exp=8", acc_cnt); end
    endtask

    task automatic test_reset_mid_wait();
        int t, s; logic [31:0] d;
        access(1'b0, 1'b1, 32'h20, 32'h11112222, t, s, d);
        @(posedge clk); #1;
        mem_wen = 1'b1; mem_addr = 32'h20; mem_dout = 32'hAAAA5555;
        @(negedge clk);   // IDLE acceptance
        @(negedge clk);   // first WAIT cycle
        cpu_rst_n = 1'b0;
        #1;
        checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL midwait_stall got=%b exp=0", mem_stall); end
        mem_wen = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        cpu_rst_n = 1'b1;
        checks++; if (acc_cnt !== 16'd0) begin errors++; $display("FAIL midwait_acc got=%0d exp=0", acc_cnt); end
        checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL midwait_err got=%b exp=0", mem_err); end
        access(1'b1, 1'b0, 32'h20, 32'h0, t, s, d);
        checks++; if (d !== 32'h11112222) begin errors++; $display("FAIL midwait_rd got=%h exp=11112222", d); end
        checks++; if (acc_cnt !== 16'd1) begin errors++; $display("FAIL midwait_acc_after got=%0d exp=1", acc_cnt); end
    endtask

    task automatic test_zero_wait();
        int t, s; logic [31:0] d;
        rst0_n = 1'b0; ren0 = 1'b0; wen0 = 1'b0; addr0 = 32'h0; dout0 = 32'h0;
        repeat (2) @(posedge clk0);
        @(negedge clk0);
        rst0_n = 1'b1;
        access0(1'b0, 1'b1, 32'h0, 32'h55AA55AA, t, s, d);
        checks++; if (t != 2) begin errors++; $display("FAIL zw_wr_cycles got=%0d exp=2", t); end
        access0(1'b1, 1'b0, 32'h0, 32'h0, t, s, d);
        checks++; if (t != 2) begin errors++; $display("FAIL zw_rd_cycles got=%0d exp=2", t); end
        checks++; if (s != 1) begin errors++; $display("FAIL zw_rd_stalls got=%0d exp=1", s); end
        checks++; if (d !== 32'h55AA55AA) begin errors++; $display("FAIL zw_rd_data got=%h exp=55aa55aa", d); end
    endtask

    task automatic test_wrap();
        rst0_n = 1'b0;
        @(posedge clk0); #1;
        @(negedge clk0);
        rst0_n = 1'b1;
        @(posedge clk0); #1;
        ren0 = 1'b1; addr0 = 32'h4;
        repeat (2 * 65535) @(posedge clk0);
        #1;
        checks++; if (acc0 !== 16'hFFFF) begin errors++; $display("FAIL wrap_pre got=%h exp=ffff", acc0); end
        repeat (2) @(posedge clk0);
        #1;
        checks++; if (acc0 !== 16'h0000) begin errors++; $display("FAIL wrap_zero got=%h exp=0000", acc0); end
        ren0 = 1'b0;
        $display("test_wrap acc0=%h", acc0);
    endtask

    initial begin
        rst0_n = 1'b0; ren0 = 1'b0; wen0 = 1'b0; addr0 = 32'h0; dout0 = 32'h0;
        test_reset();
        test_write_read();
        test_misaligned();
        test_both_high();
        test_alias();
        test_reset_mid_wait();
        test_zero_wait();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Memory-side responder for the CPU datapath's data-memory port (mem_ren/mem_wen/mem_addr/mem_dout/mem_din). It holds a word-addressed RAM and serves each read or write after a parameterised number of wait states. While an access is in flight it asserts mem_stall, which the top level folds into cpu_en. The instruction port is out of scope; this block is the data-side slave only.

Parameters:
ADDR_WIDTH, 10, log2 of RAM depth in 32-bit words (1024 words).
WAIT_CYCLES, 2, wait states inserted per access; legal range 0..15.

Ports:
clk  input  1  main clock, rising edge.
cpu_rst_n  input  1  asynchronous, active-low reset.
mem_ren  input  1  CPU read request, held by the CPU while mem_stall=1.
mem_wen  input  1  CPU write request, held by the CPU while mem_stall=1.
mem_addr  input  32  byte address; word index = mem_addr[ADDR_WIDTH+1:2].
mem_dout  input  32  write data from the CPU.
mem_din  output  32  registered read data returned to the CPU.
mem_stall  output  1  high while the CPU must hold the current request.
mem_err  output  1  sticky misalignment flag.
acc_cnt  output  16  count of completed accesses; wraps modulo 2^16.

Behaviour:
- Reset is asynchronous and active-low. While cpu_rst_n=0:
  - state=IDLE, wait counter=0, mem_din=0, mem_err=0, acc_cnt=0.
  - mem_stall is forced 0.
  - RAM contents are not cleared.
- Request: req = mem_ren | mem_wen.
- FSM states: IDLE, WAIT, DONE.
- IDLE, req=0: stay in IDLE; mem_stall=0.
- IDLE, req=1:
  - mem_stall=1 combinationally in the same cycle.
  - At the edge, latch the word index, write data, op (write if mem_wen=1, else read) and the alignment check.
  - Load the counter with WAIT_CYCLES.
  - Next state: WAIT if WAIT_CYCLES>0, else DONE.
- WAIT:
  - mem_stall=1; the counter decrements each cycle.
  - Go to DONE on the edge where the counter goes 1->0.
  - Input changes during WAIT are ignored; the latched values are used.
- DONE:
  - The access commits at the edge entering DONE:
    - write: RAM[idx] <= latched data; mem_din is unchanged.
    - read: mem_din <= RAM[idx].
  - mem_stall=0 throughout DONE, so the CPU advances at the end of DONE.
  - acc_cnt increments at the edge leaving DONE.
  - Next state is IDLE unconditionally. A req seen in DONE is the completing request and is not re-issued.
- Latency per access: WAIT_CYCLES+2 cycles, IDLE through DONE inclusive. Read data is valid in the DONE cycle and holds until the next read commits.
- Back-to-back requests: the next request is accepted in the IDLE cycle after DONE. There is no overlap.
- ren and wen both high: treated as a write; mem_din is not updated.
- Misalignment:
  - If mem_addr[1:0]!=0 at acceptance, mem_err is set and stays 1 until reset.
  - The access still proceeds on the truncated word index.
- Address bits above ADDR_WIDTH+1 are ignored, so addresses alias and wrap.
- Reset asserted mid-WAIT: the in-flight access is aborted and no RAM write occurs. After release the block is in IDLE and a held request is re-accepted.
- acc_cnt wraps from 0xFFFF to 0x0000.

Decomposition:
- Shared package dmem_pkg holds:
  - state encoding localparams: IDLE=2'd0, WAIT=2'd1, DONE=2'd2;
  - the op-code constants OP_RD and OP_WR.
- One natural sub-module, dmem_ram: single-port synchronous word RAM with ports clk, we, idx, wdata, rdata.
- FSM, counter and flags stay in dmem_responder.

Test Plan:
- Write then read, WAIT_CYCLES=2:
  - Write addr 0x10, data 0xDEADBEEF: mem_stall high for 3 cycles then low in DONE.
  - Then read 0x10: mem_din=0xDEADBEEF in DONE; total 4 cycles per access; acc_cnt=2.
- WAIT_CYCLES=0:
  - Read of 0x0 takes 2 cycles; mem_stall=1 only in the IDLE acceptance cycle.
- Misaligned access:
  - Write 0x13 with 0x12345678: mem_err=1 and stays 1.
  - Read 0x10 returns 0x12345678.
- Reset mid-WAIT:
  - Write 0x20, data 0xAAAA5555, with cpu_rst_n pulsed low during WAIT: mem_stall drops immediately.
  - A subsequent read of 0x20 returns its prior value.
  - acc_cnt resets to 0.
- ren and wen both high:
  - Write 0x1 to 0x8: mem_din keeps its old value; a following read of 0x8 returns 0x1.
- Aliasing and wrap:
  - Write 0x1000 (ADDR_WIDTH=10), then read 0x0: returns the written data.
  - Perform 65536 accesses: acc_cnt wraps to 0.
